md_seq_ctrl: RTL

//  Sequencer between the EX stage and the shared iterative mul/div engine (div_mul).

---
 rtl/md_seq_ctrl_if.sv | 48 ++++
 rtl/md_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// md_seq_ctrl_if
// Bundle of all non-clock/reset signals of md_seq_ctrl.
//   slave  modport : the sequencer (md_seq_ctrl) side
//   master modport : the environment side (EX stage, pipeline control, engine)
// Signals:
//   req_valid/req_op/req_src1/req_src2 : mul/div request from EX
//   annul, stall_mem                   : flush and downstream stall
//   eng_*                              : engine control, operands and result
//   stallreq, hilo_we, hi_o, lo_o      : pipeline stall and HI/LO write port
//   busy, err_timeout                  : status
// ---------------------------------------------------------------------------
interface md_seq_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        annul;
    logic        stall_mem;
    logic        eng_start;
    logic        eng_signed;
    logic [1:0]  eng_choose;
    logic [31:0] eng_op1;
    logic [31:0] eng_op2;
    logic        eng_annul;
    logic        eng_ready;
    logic [63:0] eng_result;
    logic        stallreq;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, annul, stall_mem,
        input  eng_ready, eng_result,
        output eng_start, eng_signed, eng_choose, eng_op1, eng_op2, eng_annul,
        output stallreq, hilo_we, hi_o, lo_o, busy, err_timeout
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, annul, stall_mem,
        output eng_ready, eng_result,
        input  eng_start, eng_signed, eng_choose, eng_op1, eng_op2, eng_annul,
        input  stallreq, hilo_we, hi_o, lo_o, busy, err_timeout
    );
endinterface

// File: rtl/md_seq_ctrl.sv
// ---------------------------------------------------------------------------
// md_seq_ctrl
// Sequencer between the EX stage and the shared iterative mul/div engine.
// Accepts one mult/multu/div/divu request, latches its operands, holds the
// engine start level and signedness stable until the engine reports ready,
// stalls the pipeline meanwhile and delivers a one-shot HI/LO write.
// Supports flush (annul) and a watchdog timeout.
//
// Ports:
//   clk         : system clock, rising edge
//   resetn      : asynchronous reset, active low
//   bus         : md_seq_ctrl_if.slave (request, engine and HI/LO signals)
//   dbg_state_o : current FSM state (0 IDLE, 1 RUN, 2 DONE)
// Parameters:
//   TIMEOUT_CYC : RUN cycles allowed before forced abort (2..255)
// Configuration macro:
//   MD_DIV0_BYPASS_EN : when defined, div/divu by zero skips the engine and
//                       completes directly with hi=src1, lo=FFFF_FFFF.
//
// Handshake: the engine sees eng_start as a level for every RUN cycle with
// operands/choose/signed frozen; eng_result is taken only in a RUN cycle
// with eng_ready=1, and eng_annul is a single-cycle abort that is always
// followed by eng_start dropping (or staying low) on the next edge.
// ---------------------------------------------------------------------------
module md_seq_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           resetn,
    md_seq_ctrl_if.slave   bus,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q, we_d;

    logic        accept;
    logic        div0_bypass;
    logic        timeout_hit;
    logic [7:0]  cnt_inc;
    logic        stallreq;
    logic        eng_annul;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        we_d        = 1'b0;
        stallreq    = 1'b0;
        eng_annul   = 1'b0;

        accept      = bus.req_valid & ~bus.annul;
        div0_bypass = 1'b0;
`ifdef MD_DIV0_BYPASS_EN
        div0_bypass = accept & bus.req_op[1] & (bus.req_src2 == 32'd0);
`endif
        // cnt_q counts completed RUN cycles; the watchdog fires in the RUN
        // cycle that brings the count up to TIMEOUT_CYC.
        cnt_inc     = cnt_q + 8'd1;
        timeout_hit = (cnt_inc == TIMEOUT_LIM);

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    // Stall in the request cycle itself so EX holds the instruction.
                    stallreq = 1'b1;
                    op_d     = bus.req_op;
                    src1_d   = bus.req_src1;
                    src2_d   = bus.req_src2;
                    if (div0_bypass) begin
                        hi_d    = bus.req_src1;
                        lo_d    = 32'hFFFF_FFFF;
                        we_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                stallreq = 1'b1;
                cnt_d    = cnt_inc;
                if (bus.annul) begin
                    // Flush beats a simultaneous ready: the result is dropped.
                    eng_annul = 1'b1;
                    state_d   = S_IDLE;
                end else if (bus.eng_ready) begin
                    hi_d    = bus.eng_result[63:32];
                    lo_d    = bus.eng_result[31:0];
                    we_d    = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    eng_annul = 1'b1;
                    err_d     = 1'b1;
                    hi_d      = 32'd0;
                    lo_d      = 32'd0;
                    we_d      = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // The instruction stays in EX while stall_mem is high; waiting
                // here keeps its still-asserted req_valid from restarting.
                if (bus.annul) begin
                    eng_annul = 1'b1;
                    state_d   = S_IDLE;
                end else if (!bus.stall_mem) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.eng_start   = (state_q == S_RUN);
    assign bus.eng_signed  = (state_q == S_RUN) & ~op_q[0];
    assign bus.eng_choose  = (state_q != S_RUN) ? 2'b00 :
                             (op_q[1] ? 2'b01 : 2'b11);
    assign bus.eng_op1     = src1_q;
    assign bus.eng_op2     = src2_q;
    assign bus.eng_annul   = eng_annul;
    assign bus.stallreq    = stallreq;
    assign bus.hilo_we     = we_q;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err_timeout = err_q;
    assign dbg_state_o     = state_q;

endmodule
